adt7301_spi_rd: RTL and testbench
=================================

Name: adt7301_spi_rd

Overview:
SPI read initiator for the ADT7301 board temperature sensor.
- Periodically, or on demand, reads one 16-bit frame (SPI mode 3, MSB first).
- Delivers the raw frame on m_axis_tdata with a one-cycle m_axis_tvalid strobe.
- Downstream, the temperature-conversion block takes this output and converts it to sign-magnitude degrees.
- Sits between the sensor pins and that converter; the data word is held stable until the next frame completes.

Parameters:
CLK_DIV, 4, SCLK half-period in clk cycles; legal range >= 4 (2-FF sdo synchroniser margin).
READ_PERIOD, 50_000_000, clk cycles between automatic reads; 0 disables auto reads (start only).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  single-cycle on-demand read request
busy  out  1  high from request acceptance until return to IDLE
spi_cs_n  out  1  sensor chip select, active-low
spi_sclk  out  1  sensor serial clock, idles high
spi_sdi  out  1  sensor DIN; constant 0 (normal mode, never shutdown)
spi_sdo  in  1  sensor DOUT, asynchronous to clk
m_axis_tdata  out  16  last frame received: [15:14] leading zeros, [13] sign, [12:0] 1/32 degC two's complement
m_axis_tvalid  out  1  one-cycle strobe when m_axis_tdata updates
frame_err  out  1  strobe coincident with tvalid when tdata[15:14] != 2'b00

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=1, spi_sdi=0, m_axis_tdata=0, m_axis_tvalid=0, frame_err=0, busy=0. The state machine goes to IDLE, and the period counter and pending request are cleared.
- Reset mid-frame aborts immediately; no partial data reaches tdata.
- Period counter:
  - Free-running 0..READ_PERIOD-1, wraps; runs in all states.
  - At count READ_PERIOD-1 it sets the pending request.
  - start=1 also sets the pending request.
- Pending request: one-deep flag.
  - Multiple requests during busy collapse into exactly one follow-up read.
  - The flag is cleared when IDLE accepts the request.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: if the pending request is set at cycle T, go to SETUP. At T+1: spi_cs_n=0, busy=1.
  - SETUP: CLK_DIV cycles with sclk=1, then SHIFT.
  - SHIFT: 16 bits, bit index 15 down to 0.
    - Each bit drives sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
    - Synchronised sdo is sampled into the shift register on the cycle sclk is driven 0->1.
    - After bit 0's high phase, go to HOLD.
  - HOLD: CLK_DIV cycles, cs_n=0, sclk=1. Then, in the same cycle:
    - spi_cs_n=1;
    - m_axis_tdata <= shift register;
    - m_axis_tvalid=1 for that one cycle;
    - frame_err evaluated;
    - go to GAP.
  - GAP: CLK_DIV cycles, cs_n=1, then IDLE; busy drops on entry to IDLE.
- Latency: tvalid at T+34*CLK_DIV+1 (CLK_DIV=4 gives T+137). Minimum request-to-request spacing is 35*CLK_DIV+1 cycles.
- spi_sdo passes through a 2-FF synchroniser before use. Sensor data changes on SCLK fall and is stable >= CLK_DIV-2 cycles before the sample point.
- m_axis_tdata is never modified except at the tvalid cycle; it stays valid after tvalid falls, so the consumer's falling-edge detect reads stable data.
- No backpressure; tvalid is a strobe.
- A start pulse coinciding with the period wrap yields one read, not two.
- spi_sclk and spi_cs_n are registered outputs; no glitches.

Decomposition:
- Shared package adt7301_pkg:
  - FRAME_BITS=16;
  - state encoding (IDLE, SETUP, SHIFT, HOLD, GAP);
  - frame field positions SIGN_BIT=13, LEAD_HI=15, LEAD_LO=14.
- One natural sub-module, sync_2ff: a 1-bit two-flop synchroniser with async active-high reset to 0, used for spi_sdo.
- Bit/phase counters and the FSM stay in adt7301_spi_rd.

Test Plan:
- Sensor model drives 0x0320 (+25 degC), CLK_DIV=4, start pulse at T -> cs_n low at T+1, 16 SCLK falling edges, tvalid at T+137 with tdata=0x0320, frame_err=0, busy low at T+142.
- Sensor drives 0x3EC0 (-10 degC) -> tdata=0x3EC0, bit13=1. tdata is still 0x3EC0 3 cycles after tvalid falls; the downstream converter yields 0x2000|0x000A.
- Sensor drives 0xC320 -> tdata=0xC320, frame_err=1 with tvalid.
- READ_PERIOD=1000, no start -> tvalid strobes exactly every 1000 cycles. Three start pulses during one busy frame -> exactly one extra frame follows, starting 1 cycle after busy drops.
- rst asserted midway through bit 7 -> same cycle async: cs_n=1, sclk=1, tdata=0, tvalid never pulses. After release, the next read returns the full correct frame.
- SDO toggling at the exact sample cycle is not allowed by the model; the check is bit-level sampling alignment. Vary CLK_DIV=4 and 9 and confirm the bit order and 0xA5C3 pattern (frame_err=1) are captured exactly.

Source files
------------

// File: rtl/adt7301_pkg.sv
// -----------------------------------------------------------------------------
// adt7301_pkg
// Shared definitions for the ADT7301 SPI read path. It holds the frame size,
// the frame field positions, the read state encoding and a helper that flags
// a malformed frame.
// -----------------------------------------------------------------------------
package adt7301_pkg;

  // One sensor transaction is a 16-bit frame, MSB first.
  localparam int FRAME_BITS = 16;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  // Frame layout: two leading zeros, a sign bit, then 13 bits of
  // two's-complement temperature in 1/32 degC steps.
  localparam int LEAD_HI  = 15;
  localparam int LEAD_LO  = 14;
  localparam int SIGN_BIT = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // A real sensor always sends zeros in the two leading positions. Anything
  // else points at a wiring or timing problem on the bus.
  function automatic logic frame_bad(input logic [FRAME_BITS-1:0] frame);
    return frame[LEAD_HI] | frame[LEAD_LO];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit. Both flops reset to 0.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset
//   d_i    asynchronous input
//   q_o    synchronised output, two clk_i cycles of latency
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adt7301_spi_rd.sv
// -----------------------------------------------------------------------------
// adt7301_spi_rd
// SPI read initiator for the ADT7301 temperature sensor (SPI mode 3, MSB
// first). It reads one 16-bit frame periodically or on request and presents
// the raw frame on m_axis_tdata with a one-cycle m_axis_tvalid strobe. The
// data word holds until the next frame completes.
// Parameters:
//   CLK_DIV      SCLK half-period in clk cycles (>= 4)
//   READ_PERIOD  clk cycles between automatic reads, 0 = start only
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   start          single-cycle on-demand read request
//   busy           high from request acceptance until back in IDLE
//   spi_cs_n       sensor chip select, active-low
//   spi_sclk       sensor serial clock, idles high
//   spi_sdi        sensor DIN, held at 0 (normal mode)
//   spi_sdo        sensor DOUT, asynchronous to clk
//   m_axis_tdata   last frame received
//   m_axis_tvalid  one-cycle strobe when m_axis_tdata updates
//   frame_err      strobe with tvalid when the leading bits are not 2'b00
// -----------------------------------------------------------------------------
module adt7301_spi_rd
  import adt7301_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int READ_PERIOD = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  spi_cs_n,
  output logic                  spi_sclk,
  output logic                  spi_sdi,
  input  logic                  spi_sdo,
  output logic [FRAME_BITS-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  frame_err
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int                PER_W    = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
  localparam logic [PER_W-1:0]  PER_LAST = (READ_PERIOD > 0) ? PER_W'(READ_PERIOD - 1) : '0;
  localparam bit                AUTO_EN  = (READ_PERIOD > 0);

  state_e                state_q;
  logic [DIV_W-1:0]      div_q;
  logic [BIT_W-1:0]      bit_q;
  logic                  sclk_q;
  logic                  cs_n_q;
  logic                  busy_q;
  logic                  pend_q;
  logic                  tvalid_q;
  logic                  ferr_q;
  logic [FRAME_BITS-1:0] tdata_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [PER_W-1:0]      per_cnt_q;
  logic [PER_W-1:0]      per_cnt_d;

  logic                  sdo_s;
  logic                  per_hit;
  logic                  req_d;
  logic                  div_done;
  logic                  sample_en;

  sync_2ff u_sdo_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (spi_sdo),
    .q_o   (sdo_s)
  );

  always_comb begin
    per_hit   = AUTO_EN && (per_cnt_q == PER_LAST);
    per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
    // start, the period tick and a pending flag all merge into one request,
    // so a start that lands on the period wrap still produces a single read.
    req_d     = pend_q | start | per_hit;
    div_done  = (div_q == DIV_LAST);
    // Sample on the last low cycle, i.e. the cycle that drives SCLK 0->1.
    sample_en = (state_q == ST_SHIFT) && div_done && !sclk_q;
  end

  // Free-running period counter; it runs in every state so the read cadence
  // does not drift with frame length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  // Shift register carries only data and needs no reset: tdata is loaded from
  // it solely at the end of a complete frame.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], sdo_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      // Requests arriving while busy collapse into this one-deep flag.
      pend_q   <= req_d;

      case (state_q)
        ST_IDLE: begin
          if (req_d) begin
            state_q <= ST_SETUP;
            pend_q  <= 1'b0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
          end
        end

        ST_SETUP: begin
          if (div_done) begin
            state_q <= ST_SHIFT;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= BIT_W'(FRAME_BITS - 1);
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (div_done) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == '0) begin
              // SCLK stays high through HOLD, as mode 3 idles high.
              state_q <= ST_HOLD;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q - 1'b1;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (div_done) begin
            state_q  <= ST_GAP;
            cs_n_q   <= 1'b1;
            tdata_q  <= shift_q;
            tvalid_q <= 1'b1;
            ferr_q   <= frame_bad(shift_q);
            div_q    <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        ST_GAP: begin
          if (div_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            div_q   <= '0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          div_q   <= '0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_sclk      = sclk_q;
  assign spi_sdi       = 1'b0;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_adt7301_spi_rd.sv
// -----------------------------------------------------------------------------
// tb_adt7301_spi_rd
// Directed bench for adt7301_spi_rd. Instance A (CLK_DIV=4, start only) covers
// latency, data patterns, request collapsing and reset abort. Instance B
// (CLK_DIV=9, READ_PERIOD=1000) covers automatic reads and slow-clock capture.
// Each instance has a small sensor model that shifts out a word, changing
// DOUT just after each SCLK fall.
// -----------------------------------------------------------------------------
module tb_adt7301_spi_rd;
  import adt7301_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic        busy_a, cs_n_a, sclk_a, sdi_a, tvalid_a, ferr_a;
  logic [15:0] tdata_a;
  logic        sdo_a = 1'b0;
  logic [15:0] word_a = 16'h0000;
  int          idx_a = 15;
  int          nfall_a = 0;

  logic        busy_b, cs_n_b, sclk_b, sdi_b, tvalid_b, ferr_b;
  logic [15:0] tdata_b;
  logic        sdo_b = 1'b0;
  logic [15:0] word_b = 16'hA5C3;
  int          idx_b = 15;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adt7301_spi_rd #(.CLK_DIV(4), .READ_PERIOD(0)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .start         (start_a),
    .busy          (busy_a),
    .spi_cs_n      (cs_n_a),
    .spi_sclk      (sclk_a),
    .spi_sdi       (sdi_a),
    .spi_sdo       (sdo_a),
    .m_axis_tdata  (tdata_a),
    .m_axis_tvalid (tvalid_a),
    .frame_err     (ferr_a)
  );

  adt7301_spi_rd #(.CLK_DIV(9), .READ_PERIOD(1000)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .start         (start_b),
    .busy          (busy_b),
    .spi_cs_n      (cs_n_b),
    .spi_sclk      (sclk_b),
    .spi_sdi       (sdi_b),
    .spi_sdo       (sdo_b),
    .m_axis_tdata  (tdata_b),
    .m_axis_tvalid (tvalid_b),
    .frame_err     (ferr_b)
  );

  // Sensor models: restart at the MSB whenever CS is released, present the
  // next bit 1 ns after every SCLK fall while selected.
  always @(posedge cs_n_a or negedge sclk_a) begin
    if (cs_n_a) begin
      idx_a = 15;
    end else begin
      #1;
      if (idx_a >= 0) begin
        sdo_a = word_a[idx_a];
        idx_a = idx_a - 1;
      end
    end
  end

  always @(posedge cs_n_b or negedge sclk_b) begin
    if (cs_n_b) begin
      idx_b = 15;
    end else begin
      #1;
      if (idx_b >= 0) begin
        sdo_b = word_b[idx_b];
        idx_b = idx_b - 1;
      end
    end
  end

  always @(negedge sclk_a) nfall_a <= nfall_a + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Downstream converter: sign-magnitude whole degrees, sign in bit 13.
  function automatic logic [15:0] to_signmag(input logic [15:0] f);
    logic [12:0] mag;
    mag = f[SIGN_BIT] ? (~f[12:0] + 13'd1) : f[12:0];
    return {2'b00, f[SIGN_BIT], 5'b0, mag[12:5]};
  endfunction

  // Start pulse; t0 is the cycle in which start is high.
  task automatic pulse_start(output int t0);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start_a = 1'b0;
  endtask

  task automatic wait_vld_a(input string tag, input int budget, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tvalid_a) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_vld_b(input string tag, input int budget, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tvalid_b) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_vld_a(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (tvalid_a) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t, tb1, tb2, tb3, f0, n;
    bit dropped;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn",    cs_n_a,   1'b1);
    check("rst_sclk",   sclk_a,   1'b1);
    check("rst_sdi",    sdi_a,    1'b0);
    check("rst_tdata",  tdata_a,  16'h0000);
    check("rst_tvalid", tvalid_a, 1'b0);
    check("rst_ferr",   ferr_a,   1'b0);
    check("rst_busy",   busy_a,   1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // +25 degC frame, latency and timing
    word_a = 16'h0320;
    f0 = nfall_a;
    pulse_start(t0);
    check("t1_csn_low", cs_n_a, 1'b0);
    check("t1_busy_hi", busy_a, 1'b1);
    wait_vld_a("t1", 400, t);
    check("t1_latency", t - t0, 137);
    check("t1_tdata",   tdata_a, 16'h0320);
    check("t1_ferr",    ferr_a,  1'b0);
    check("t1_csn_hi",  cs_n_a,  1'b1);
    check("t1_nfall",   nfall_a - f0, 16);
    repeat (3) @(posedge clk);
    #1;
    check("t1_busy_140", busy_a, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("t1_busy_142", busy_a, 1'b0);

    // -10 degC frame; data must stay put after the strobe
    word_a = 16'h3EC0;
    pulse_start(t0);
    wait_vld_a("t2", 400, t);
    check("t2_tdata", tdata_a, 16'h3EC0);
    check("t2_sign",  tdata_a[SIGN_BIT], 1'b1);
    check("t2_ferr",  ferr_a, 1'b0);
    @(posedge clk);
    #1;
    check("t2_vld_low", tvalid_a, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_hold",    tdata_a, 16'h3EC0);
    check("t2_convert", to_signmag(tdata_a), 16'h200A);
    repeat (8) @(posedge clk);

    // Leading bits set -> frame error
    word_a = 16'hC320;
    pulse_start(t0);
    wait_vld_a("t3", 400, t);
    check("t3_tdata", tdata_a, 16'hC320);
    check("t3_ferr",  ferr_a,  1'b1);
    repeat (8) @(posedge clk);

    // Three starts during one frame collapse into one follow-up frame
    word_a = 16'h0190;
    pulse_start(t0);
    repeat (20) @(posedge clk);
    pulse_start(t);
    repeat (40) @(posedge clk);
    pulse_start(t);
    repeat (30) @(posedge clk);
    pulse_start(t);
    wait_vld_a("t4a", 400, t);
    check("t4_tdata1", tdata_a, 16'h0190);
    dropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!busy_a) begin
        dropped = 1'b1;
        break;
      end
    end
    check("t4_busy_drop", dropped, 1'b1);
    @(posedge clk);
    #1;
    check("t4_follow_csn",  cs_n_a, 1'b0);
    check("t4_follow_busy", busy_a, 1'b1);
    wait_vld_a("t4b", 400, t);
    check("t4_tdata2", tdata_a, 16'h0190);
    count_vld_a(400, n);
    check("t4_no_third", n, 0);

    // Reset midway through bit 7 aborts the frame
    word_a = 16'h0560;
    pulse_start(t0);
    repeat (72) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_csn",   cs_n_a,   1'b1);
    check("t5_sclk",  sclk_a,   1'b1);
    check("t5_tdata", tdata_a,  16'h0000);
    check("t5_vld",   tvalid_a, 1'b0);
    check("t5_busy",  busy_a,   1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    count_vld_a(300, n);
    check("t5_no_vld", n, 0);
    word_a = 16'h1234;
    pulse_start(t0);
    wait_vld_a("t5", 400, t);
    check("t5_latency", t - t0, 137);
    check("t5_tdata",   tdata_a, 16'h1234);
    check("t5_ferr",    ferr_a,  1'b0);
    repeat (8) @(posedge clk);

    // Bit order at CLK_DIV=4
    word_a = 16'hA5C3;
    pulse_start(t0);
    wait_vld_a("t6", 400, t);
    check("t6_tdata", tdata_a, 16'hA5C3);
    check("t6_ferr",  ferr_a,  1'b1);

    // Automatic reads every 1000 cycles at CLK_DIV=9
    wait_vld_b("t7a", 2500, tb1);
    check("t7_tdata", tdata_b, 16'hA5C3);
    check("t7_ferr",  ferr_b,  1'b1);
    wait_vld_b("t7b", 1500, tb2);
    check("t7_period1", tb2 - tb1, 1000);
    wait_vld_b("t7c", 1500, tb3);
    check("t7_period2", tb3 - tb2, 1000);
    check("t7_tdata3",  tdata_b, 16'hA5C3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
